// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART byte transmitter among NREQ producers.
// Define UART_ARB_LOCK_EN to add the lock input that holds the grant across multi-byte messages.
module uart_tx_arbiter #(
  parameter int NREQ = 4,
  parameter int WDOG = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [8*NREQ-1:0]       data_in,
`ifdef UART_ARB_LOCK_EN
  input  logic [NREQ-1:0]         lock,
`endif
  output logic [NREQ-1:0]         ack,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic [7:0]              tx_data,
  output logic                    tx_send,
  input  logic                    tx_ready
);

  localparam int GW = $clog2(NREQ);
  localparam int CW = (WDOG > 2) ? $clog2(WDOG) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND      = 3'd1,
    WAIT_LOW  = 3'd2,
    WAIT_HIGH = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t            state_r;
  logic [GW-1:0]     ptr_r;
  logic [CW-1:0]     cnt_r;
  logic [NREQ-1:0]   elig_s;
  logic [NREQ-1:0]   rot_s;
  logic [GW-1:0]     off_s;
  logic [GW:0]       sum_s;
  logic [GW-1:0]     win_s;
  logic [7:0]        win_byte_s;
  logic              any_s;
  logic [GW-1:0]     ptr_next_s;
  logic [NREQ-1:0]   owner_1h_s;
`ifdef UART_ARB_LOCK_EN
  logic              locked_r;
  logic              lock_hold_s;
`endif

  assign owner_1h_s = {{(NREQ-1){1'b0}}, 1'b1} << grant_id;
  assign ptr_next_s = (grant_id == GW'(NREQ - 1)) ? '0 : grant_id + GW'(1);

  // Eligible requests, round-robin scan upward from ptr_r, and the winner's byte
  always_comb begin
    elig_s = req;
`ifdef UART_ARB_LOCK_EN
    lock_hold_s = locked_r & lock[grant_id];
    if (lock_hold_s) begin
      elig_s = req & owner_1h_s;
    end else begin
      elig_s = req;
    end
`endif
    any_s = |elig_s;
    rot_s = NREQ'({elig_s, elig_s} >> ptr_r);
    off_s = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      off_s = rot_s[k] ? GW'(k) : off_s;
    end
    sum_s = {1'b0, ptr_r} + {1'b0, off_s};
    win_s = (sum_s >= (GW+1)'(NREQ)) ? GW'(sum_s - (GW+1)'(NREQ)) : sum_s[GW-1:0];
    win_byte_s = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      win_byte_s = (win_s == GW'(i)) ? data_in[8*i +: 8] : win_byte_s;
    end
  end

  // Arbiter FSM; every output is a register updated on state transitions
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      ptr_r    <= '0;
      cnt_r    <= '0;
      ack      <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      tx_data  <= 8'h00;
      tx_send  <= 1'b0;
`ifdef UART_ARB_LOCK_EN
      locked_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          ack   <= '0;
          cnt_r <= '0;
`ifdef UART_ARB_LOCK_EN
          locked_r <= lock_hold_s;
`endif
          if (tx_ready && any_s) begin
            state_r  <= SEND;
            grant_id <= win_s;
            tx_data  <= win_byte_s;
            tx_send  <= 1'b1;
            busy     <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        SEND: begin
          tx_send <= 1'b0;
          cnt_r   <= '0;
          state_r <= WAIT_LOW;
        end
        WAIT_LOW: begin
          // A transmitter that never drops ready is assumed to have absorbed the byte
          if (!tx_ready) begin
            state_r <= WAIT_HIGH;
          end else if (cnt_r == CW'(WDOG - 1)) begin
            state_r <= DONE;
            ack     <= owner_1h_s;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        WAIT_HIGH: begin
          if (tx_ready) begin
            state_r <= DONE;
            ack     <= owner_1h_s;
          end else begin
            state_r <= WAIT_HIGH;
          end
        end
        DONE: begin
          ack     <= '0;
          busy    <= 1'b0;
          state_r <= IDLE;
`ifdef UART_ARB_LOCK_EN
          if (lock[grant_id]) begin
            locked_r <= 1'b1;
          end else begin
            locked_r <= 1'b0;
            ptr_r    <= ptr_next_s;
          end
`else
          ptr_r <= ptr_next_s;
`endif
        end
        default: begin
          state_r <= IDLE;
          ack     <= '0;
          busy    <= 1'b0;
          tx_send <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table of single transactions plus
// hand-written watchdog, ready-stall, mid-frame reset and (when enabled) lock sequences.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] data_in;
`ifdef UART_ARB_LOCK_EN
  logic [3:0]  lock;
`endif
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic        busy;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic        tx_ready = 1'b1;

  uart_tx_arbiter #(.NREQ(4), .WDOG(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .data_in  (data_in),
`ifdef UART_ARB_LOCK_EN
    .lock     (lock),
`endif
    .ack      (ack),
    .grant_id (grant_id),
    .busy     (busy),
    .tx_data  (tx_data),
    .tx_send  (tx_send),
    .tx_ready (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Transmitter stand-in: ready falls one cycle after tx_send and stays low low_len cycles
  int low_len = 4;
  bit wd_mode = 1'b0;
  bit stall_low = 1'b0;
  int tx_cnt = 0;
  bit seen_send = 1'b0;
  always begin
    @(posedge clk);
    #2;
    if (seen_send) begin
      tx_ready = 1'b0;
      tx_cnt = low_len;
      seen_send = 1'b0;
    end else if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) tx_ready = 1'b1;
    end else begin
      tx_ready = !stall_low;
    end
    if (tx_send && !wd_mode) seen_send = 1'b1;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_send(input int budget, output int at);
    int n = 0;
    while (tx_send !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk("send_seen", {31'd0, tx_send}, 32'd1);
    at = cyc;
  endtask

  task automatic wait_ack(input int budget, output int at);
    int n = 0;
    while (ack === 4'b0000 && n < budget) begin
      tick();
      n++;
    end
    chk("ack_seen", {31'd0, (ack !== 4'b0000)}, 32'd1);
    at = cyc;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [1:0]  grant;
    logic [7:0]  byte_v;
    logic [3:0]  ack;
    int          low_len;
  } vec_t;

  vec_t vec[10];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t_send;
    int t_ack;
    int prev_ack;
    int cnt;

    vec[0] = '{4'b0001, 32'h0000_0095, 2'd0, 8'h95, 4'b0001, 200};
    vec[1] = '{4'b1010, 32'hB300_A100, 2'd1, 8'hA1, 4'b0010, 4};
    vec[2] = '{4'b1010, 32'hB300_A100, 2'd3, 8'hB3, 4'b1000, 4};
    vec[3] = '{4'b1010, 32'hB300_A100, 2'd1, 8'hA1, 4'b0010, 4};
    vec[4] = '{4'b1010, 32'hB300_A100, 2'd3, 8'hB3, 4'b1000, 4};
    vec[5] = '{4'b1001, 32'hD300_00C0, 2'd0, 8'hC0, 4'b0001, 3};
    vec[6] = '{4'b1001, 32'hD300_00C0, 2'd3, 8'hD3, 4'b1000, 3};
    vec[7] = '{4'b1110, 32'h3322_1100, 2'd1, 8'h11, 4'b0010, 2};
    vec[8] = '{4'b1100, 32'h3322_1100, 2'd2, 8'h22, 4'b0100, 2};
    vec[9] = '{4'b0101, 32'h0044_0055, 2'd0, 8'h55, 4'b0001, 5};

    rst = 1'b1;
    req = 4'b0000;
    data_in = 32'h0;
`ifdef UART_ARB_LOCK_EN
    lock = 4'b0000;
`endif
    repeat (2) tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ack", {28'd0, ack}, 32'd0);
    chk("rst_send", {31'd0, tx_send}, 32'd0);
    chk("rst_grant", {30'd0, grant_id}, 32'd0);
    chk("rst_txdata", {24'd0, tx_data}, 32'd0);
    rst = 1'b0;
    tick();

    // Table: one complete transaction per entry; next request posted at the ack edge
    prev_ack = 0;
    for (int i = 0; i < 10; i++) begin
      req = vec[i].req;
      data_in = vec[i].data;
      low_len = vec[i].low_len;
      wait_send(50, t_send);
      chk("v_grant", {30'd0, grant_id}, {30'd0, vec[i].grant});
      chk("v_data", {24'd0, tx_data}, {24'd0, vec[i].byte_v});
      chk("v_busy", {31'd0, busy}, 32'd1);
      if (i > 0) chk("v_gap", t_send - prev_ack, 32'd2);
      tick();
      chk("v_send_pulse", {31'd0, tx_send}, 32'd0);
      wait_ack(400, t_ack);
      chk("v_ack", {28'd0, ack}, {28'd0, vec[i].ack});
      chk("v_ack_lat", t_ack - t_send, vec[i].low_len + 2);
      prev_ack = t_ack;
      tick();
      chk("v_ack_pulse", {28'd0, ack}, 32'd0);
    end
    req = 4'b0000;

    // Watchdog: ready never falls, ack WDOG+1 cycles after tx_send
    wd_mode = 1'b1;
    tick();
    req = 4'b0100;
    data_in = 32'h005A_0000;
    wait_send(20, t_send);
    chk("wd_grant", {30'd0, grant_id}, 32'd2);
    wait_ack(30, t_ack);
    chk("wd_lat", t_ack - t_send, 32'd9);
    chk("wd_ack", {28'd0, ack}, 32'h4);
    tick();
    req = 4'b0000;
    chk("wd_idle", {31'd0, busy}, 32'd0);
    chk("wd_hold_data", {24'd0, tx_data}, 32'h5A);
    wd_mode = 1'b0;

    // tx_ready low in IDLE: no grant until it returns
    stall_low = 1'b1;
    low_len = 3;
    repeat (2) tick();
    req = 4'b0010;
    data_in = 32'h0000_7700;
    cnt = 0;
    repeat (6) begin
      tick();
      if (tx_send || busy) cnt++;
    end
    chk("stall_nogrant", cnt, 32'd0);
    stall_low = 1'b0;
    wait_send(10, t_send);
    chk("stall_grant", {30'd0, grant_id}, 32'd1);
    chk("stall_data", {24'd0, tx_data}, 32'h77);
    wait_ack(30, t_ack);
    tick();
    req = 4'b0000;

    // Reset during WAIT_HIGH aborts silently and restores priority to requester 0
    low_len = 20;
    tick();
    req = 4'b0001;
    data_in = 32'h0000_00E1;
    wait_send(10, t_send);
    repeat (4) tick();
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_ack", {28'd0, ack}, 32'd0);
    chk("mrst_send", {31'd0, tx_send}, 32'd0);
    chk("mrst_grant", {30'd0, grant_id}, 32'd0);
    tick();
    rst = 1'b0;
    low_len = 3;
    req = 4'b1001;
    data_in = 32'hE300_00E2;
    wait_send(60, t_send);
    chk("mrst_next_grant", {30'd0, grant_id}, 32'd0);
    chk("mrst_next_data", {24'd0, tx_data}, 32'hE2);
    wait_ack(30, t_ack);
    chk("mrst_next_ack", {28'd0, ack}, 32'h1);
    tick();
    req = 4'b0000;

`ifdef UART_ARB_LOCK_EN
    // Locked owner 0 sends three bytes while requester 2 waits
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b0101;
    lock = 4'b0001;
    data_in = 32'h0052_0031;
    for (int k = 0; k < 3; k++) begin
      wait_send(20, t_send);
      chk("lock_grant", {30'd0, grant_id}, 32'd0);
      chk("lock_data", {24'd0, tx_data}, 32'h31 + k);
      wait_ack(30, t_ack);
      chk("lock_ack", {28'd0, ack}, 32'h1);
      tick();
      data_in = {8'h00, 8'h52, 8'h00, 8'h32 + 8'(k)};
      if (k == 2) begin
        req = 4'b0100;
        lock = 4'b0000;
      end
    end
    wait_send(20, t_send);
    chk("unlock_grant", {30'd0, grant_id}, 32'd2);
    chk("unlock_data", {24'd0, tx_data}, 32'h52);
    wait_ack(30, t_ack);
    tick();
    req = 4'b0000;
`endif

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
